// File: rtl/cmp_search.sv
// Binary search for a 2-bit target through an external comparator.
// Each guess is held on {a1,a2} for SETTLE cycles before the flags are sampled.
module cmp_search #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       red,
    input  logic       green,
    input  logic       blue,
    output logic       a1,
    output logic       a2,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] found,
    output logic [1:0] probes
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BND_W = 3;
    localparam int unsigned PRB_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_EVAL   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [BND_W-1:0]   lo_q, lo_d;
    logic [BND_W-1:0]   hi_q, hi_d;
    logic [BND_W-1:0]   guess_q, guess_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRB_W-1:0]   probes_q, probes_d;
    logic [1:0]         found_q, found_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               flag_eq, flag_gt, flag_lt;
    logic               step_ok;
    logic               settle_last;
    logic [BND_W-1:0]   lo_upd, hi_upd;

    // Comparator flag decode; anything outside eq/gt/lt is inconsistent.
    assign flag_eq     = ~blue &  red &  green;
    assign flag_gt     =  blue &  red & ~green;
    assign flag_lt     =  blue & ~red &  green;
    assign step_ok     = (flag_gt && (guess_q != BND_W'(0))) ||
                         (flag_lt && (guess_q != BND_W'(3)));
    assign settle_last = (cnt_q == CNT_W'(SETTLE - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_last) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (flag_eq)      state_d = S_DONE;
                else if (step_ok) state_d = S_SETTLE;
                else              state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        cnt_d    = cnt_q;
        probes_d = probes_q;
        found_d  = found_q;
        done_d   = done_q;
        err_d    = err_q;
        busy_d   = busy_q;
        lo_upd   = lo_q;
        hi_upd   = hi_q;
        if (flag_gt) hi_upd = guess_q - BND_W'(1);
        if (flag_lt) lo_upd = guess_q + BND_W'(1);
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    lo_d     = BND_W'(0);
                    hi_d     = BND_W'(3);
                    guess_d  = BND_W'(1);
                    cnt_d    = CNT_W'(0);
                    probes_d = PRB_W'(0);
                    found_d  = 2'd0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_EVAL: begin
                probes_d = probes_q + PRB_W'(1);
                if (flag_eq) begin
                    found_d = guess_q[1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (step_ok) begin
                    // Bounds stay in 0..3 because the edge guesses are routed to ERR.
                    lo_d    = lo_upd;
                    hi_d    = hi_upd;
                    guess_d = (lo_upd + hi_upd) >> 1;
                    cnt_d   = CNT_W'(0);
                end else begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            cnt_q    <= '0;
            probes_q <= '0;
            found_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            cnt_q    <= cnt_d;
            probes_q <= probes_d;
            found_q  <= found_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign a1     = guess_q[1];
    assign a2     = guess_q[0];
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign found  = found_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search: comparator model, directed scenarios
// and randomized searches checked against the fixed search-order table.
module tb_cmp_search;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst, start, red, green, blue;
    logic       a1, a2, busy, done, err;
    logic [1:0] found, probes;

    int         target;
    bit         force_bad, noise;
    logic [2:0] noise_v;
    int         n_cmp = 0;
    int         n_err = 0;

    cmp_search #(.SETTLE(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .a1     (a1),
        .a2     (a2),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .found  (found),
        .probes (probes)
    );

    always #5 clk = ~clk;

    // Comparator model, optionally overridden by a stuck pattern or noise.
    always_comb begin
        if (force_bad) begin
            {red, green, blue} = 3'b111;
        end else if (noise) begin
            {red, green, blue} = noise_v;
        end else begin
            red   = (int'({a1, a2}) >= target);
            green = (int'({a1, a2}) <= target);
            blue  = (int'({a1, a2}) != target);
        end
    end

    function automatic int n_probes(input int t);
        case (t)
            1:       return 1;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    // Fixed search order: 1 first, then 0 or 2, then 3.
    function automatic int guess_at(input int t, input int p);
        if (p == 0) return 1;
        if (t == 0) return 0;
        if (p == 1) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        n_cmp++;
        assert (obs === 8'(exp)) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, 8'(exp));
        end
    endtask

    // Call at a negedge; pulses start and follows the search to completion.
    task automatic run_search(input int t, input bit restart, input bit use_noise);
        int p_exp;
        int lat;
        p_exp     = n_probes(t);
        lat       = p_exp * (S + 1);
        target    = t;
        force_bad = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        for (int j = 0; j < lat; j++) begin
            chk("busy_run",  8'(busy), 1);
            chk("done_low",  8'(done), 0);
            chk("err_low",   8'(err), 0);
            chk("guess_seq", 8'({a1, a2}), guess_at(t, j / (S + 1)));
            start   = restart && ((j == 0) || ($urandom_range(0, 1) == 1));
            noise   = use_noise && ((j % (S + 1)) != S);
            noise_v = 3'($urandom);
            @(negedge clk);
        end
        start   = 1'b0;
        noise   = use_noise;
        noise_v = 3'($urandom);
        chk("done_set",   8'(done), 1);
        chk("busy_clr",   8'(busy), 0);
        chk("err_clr",    8'(err), 0);
        chk("found",      8'(found), t);
        chk("probes",     8'(probes), p_exp);
        chk("guess_last", 8'({a1, a2}), guess_at(t, p_exp - 1));
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            noise_v = 3'($urandom);
            chk("hold_done",  8'(done), 1);
            chk("hold_found", 8'(found), t);
            chk("hold_prb",   8'(probes), p_exp);
            chk("hold_guess", 8'({a1, a2}), guess_at(t, p_exp - 1));
        end
        noise = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        force_bad = 1'b0;
        noise     = 1'b0;
        noise_v   = 3'd0;
        target    = 0;
        @(negedge clk);
        chk("rst_guess",  8'({a1, a2}), 0);
        chk("rst_busy",   8'(busy), 0);
        chk("rst_done",   8'(done), 0);
        chk("rst_err",    8'(err), 0);
        chk("rst_found",  8'(found), 0);
        chk("rst_probes", 8'(probes), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_guess", 8'({a1, a2}), 0);
        chk("idle_busy",  8'(busy), 0);

        run_search(1, 1'b0, 1'b0);
        run_search(3, 1'b0, 1'b0);
        run_search(0, 1'b0, 1'b0);
        run_search(2, 1'b0, 1'b0);
        run_search(3, 1'b1, 1'b0);

        // Inconsistent flags on the first probe.
        target    = 1;
        force_bad = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 1) @(negedge clk);
        chk("bad_err",    8'(err), 1);
        chk("bad_done",   8'(done), 0);
        chk("bad_busy",   8'(busy), 0);
        chk("bad_probes", 8'(probes), 1);
        chk("bad_guess",  8'({a1, a2}), 1);
        force_bad = 1'b0;
        @(negedge clk);
        chk("err_hold", 8'(err), 1);
        run_search(2, 1'b0, 1'b1);

        // Asynchronous reset in the middle of SETTLE.
        target = 3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_guess",  8'({a1, a2}), 0);
        chk("arst_busy",   8'(busy), 0);
        chk("arst_done",   8'(done), 0);
        chk("arst_err",    8'(err), 0);
        chk("arst_found",  8'(found), 0);
        chk("arst_probes", 8'(probes), 0);
        @(negedge clk);
        rst = 1'b0;
        run_search(2, 1'b0, 1'b0);

        repeat (16) begin
            run_search(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
